// File: rtl/led_frame_sequencer.sv
// Frame-level sequencer between the pixel RAM and the LED stripe bit encoder.
// Optional build macro LED_SEQ_AUTO_REFRESH_EN: frames repeat until auto_refresh_stop.
module led_frame_sequencer #(
  parameter int NUM_LEDS     = 64,
  parameter int BPP          = 24,
  parameter int ADDR_W       = 6,
  parameter int RESET_CYCLES = 2500
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              frame_start,
  output logic              busy,
  output logic              frame_done,
  output logic              pix_rd_en,
  output logic [ADDR_W-1:0] pix_addr,
  input  logic [BPP-1:0]    pix_data,
  input  logic              new_bit_rqst,
  output logic              bit_to_transmit,
  output logic              all_bits_shifted,
  output logic              reset_finish
`ifdef LED_SEQ_AUTO_REFRESH_EN
  ,
  input  logic              auto_refresh_stop
`endif
);

  localparam int BC_W = (BPP > 1) ? $clog2(BPP) : 1;
  localparam int RC_W = $clog2(RESET_CYCLES);

  localparam logic [BC_W-1:0]   BIT_LAST = BC_W'(BPP - 1);
  localparam logic [ADDR_W-1:0] PIX_LAST = ADDR_W'(NUM_LEDS - 1);
  localparam logic [RC_W-1:0]   RST_LAST = RC_W'(RESET_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRIME_WAIT,
    S_PRIME_LOAD,
    S_PRIME_FILL,
    S_SHIFT,
    S_LATCH
  } state_t;

  state_t            state;
  logic [BPP-1:0]    shift_reg;
  logic [BPP-1:0]    next_reg;
  logic              next_valid;
  logic              pending;
  logic              refill_req;
  logic [1:0]        fill_stage;
  logic [BC_W-1:0]   bit_cnt;
  logic [ADDR_W-1:0] pix_cnt;
  logic [RC_W-1:0]   rst_cnt;

  logic serve;
  logic last_bit;
  logic more_pix;

  assign bit_to_transmit = shift_reg[BPP-1];
  assign serve           = (state == S_SHIFT) && (new_bit_rqst || pending);
  assign last_bit        = (bit_cnt == BIT_LAST);
  assign more_pix        = (pix_cnt != PIX_LAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      // NOTE: every datapath register is reset so a mid-frame reset leaves nothing stale behind.
      state            <= S_IDLE;
      busy             <= 1'b0;
      frame_done       <= 1'b0;
      pix_rd_en        <= 1'b0;
      pix_addr         <= '0;
      all_bits_shifted <= 1'b0;
      reset_finish     <= 1'b0;
      shift_reg        <= '0;
      next_reg         <= '0;
      next_valid       <= 1'b0;
      pending          <= 1'b0;
      refill_req       <= 1'b0;
      fill_stage       <= '0;
      bit_cnt          <= '0;
      pix_cnt          <= '0;
      rst_cnt          <= '0;
    end else begin
      // NOTE: non-blocking assignments only; later assignments in this block override earlier defaults.
      pix_rd_en    <= 1'b0;
      frame_done   <= 1'b0;
      reset_finish <= 1'b0;

      // Prefetch pipeline: read strobe -> RAM latency -> capture into next_reg.
      fill_stage <= {fill_stage[0], 1'b0};
      if (fill_stage[1]) begin
        next_reg   <= pix_data;
        next_valid <= 1'b1;
      end
      if (refill_req) begin
        refill_req <= 1'b0;
        pix_rd_en  <= 1'b1;
        pix_addr   <= pix_cnt + ADDR_W'(1);
        fill_stage <= {fill_stage[0], 1'b1};
      end

      case (state)
        S_IDLE: begin
          // frame_done is still high in the cycle after a frame ends; a request there is dropped.
          if (frame_start && !frame_done) begin
            busy      <= 1'b1;
            pix_rd_en <= 1'b1;
            pix_addr  <= '0;
            pix_cnt   <= '0;
            bit_cnt   <= '0;
            pending   <= 1'b0;
            state     <= S_PRIME_WAIT;
          end
        end

        S_PRIME_WAIT: begin
          pending <= pending | new_bit_rqst;
          state   <= S_PRIME_LOAD;
        end

        S_PRIME_LOAD: begin
          pending   <= pending | new_bit_rqst;
          shift_reg <= pix_data;
          if (NUM_LEDS > 1) begin
            pix_rd_en  <= 1'b1;
            pix_addr   <= ADDR_W'(1);
            fill_stage <= {fill_stage[0], 1'b1};
            state      <= S_PRIME_FILL;
          end else begin
            state <= S_SHIFT;
          end
        end

        S_PRIME_FILL: begin
          pending <= pending | new_bit_rqst;
          if (fill_stage[1]) state <= S_SHIFT;
        end

        S_SHIFT: begin
          if (serve) begin
            pending <= 1'b0;
            if (!last_bit) begin
              shift_reg <= {shift_reg[BPP-2:0], 1'b0};
              bit_cnt   <= bit_cnt + BC_W'(1);
            end else if (more_pix) begin
              shift_reg  <= next_reg;
              next_valid <= 1'b0;
              bit_cnt    <= '0;
              pix_cnt    <= pix_cnt + ADDR_W'(1);
              refill_req <= ((pix_cnt + ADDR_W'(1)) != PIX_LAST);
            end else begin
              all_bits_shifted <= 1'b1;
              shift_reg        <= '0;
              rst_cnt          <= '0;
              state            <= S_LATCH;
            end
          end
        end

        S_LATCH: begin
          if (rst_cnt == RST_LAST) begin
            reset_finish     <= 1'b1;
            frame_done       <= 1'b1;
            all_bits_shifted <= 1'b0;
            rst_cnt          <= '0;
`ifdef LED_SEQ_AUTO_REFRESH_EN
            if (!auto_refresh_stop) begin
              pix_rd_en <= 1'b1;
              pix_addr  <= '0;
              pix_cnt   <= '0;
              bit_cnt   <= '0;
              pending   <= 1'b0;
              state     <= S_PRIME_WAIT;
            end else begin
              busy  <= 1'b0;
              state <= S_IDLE;
            end
`else
            busy  <= 1'b0;
            state <= S_IDLE;
`endif
          end else begin
            rst_cnt <= rst_cnt + RC_W'(1);
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_led_frame_sequencer.sv
// Directed bench for led_frame_sequencer; define LED_SEQ_AUTO_REFRESH_EN to run the auto-refresh scenario.
module tb_led_frame_sequencer;

`ifdef LED_SEQ_AUTO_REFRESH_EN
  localparam int NUM_LEDS = 1;
`else
  localparam int NUM_LEDS = 2;
`endif
  localparam int BPP    = 24;
  localparam int ADDR_W = 2;
  localparam int RC     = 40;
  localparam int GAP    = 60;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              frame_start = 1'b0;
  logic              new_bit_rqst = 1'b0;
  logic              busy, frame_done, pix_rd_en, bit_to_transmit, all_bits_shifted, reset_finish;
  logic [ADDR_W-1:0] pix_addr;
  logic [BPP-1:0]    pix_data;
`ifdef LED_SEQ_AUTO_REFRESH_EN
  logic              auto_refresh_stop = 1'b0;
`endif

  logic [BPP-1:0] mem [4];
  logic [BPP-1:0] ram_q = '0;

  int n_tests = 0;
  int n_fail  = 0;
  int rd_count = 0;
  int rf_count = 0;
  int addr_err = 0;
  logic [ADDR_W-1:0] rd_log [64];

  led_frame_sequencer #(
    .NUM_LEDS(NUM_LEDS), .BPP(BPP), .ADDR_W(ADDR_W), .RESET_CYCLES(RC)
  ) dut (
    .clk(clk), .rstn(rstn), .frame_start(frame_start), .busy(busy),
    .frame_done(frame_done), .pix_rd_en(pix_rd_en), .pix_addr(pix_addr),
    .pix_data(pix_data), .new_bit_rqst(new_bit_rqst),
    .bit_to_transmit(bit_to_transmit), .all_bits_shifted(all_bits_shifted),
    .reset_finish(reset_finish)
`ifdef LED_SEQ_AUTO_REFRESH_EN
    , .auto_refresh_stop(auto_refresh_stop)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous-read pixel RAM: data valid one cycle after the read strobe.
  always @(posedge clk) if (pix_rd_en) ram_q <= mem[pix_addr];
  assign pix_data = ram_q;

  always @(negedge clk) begin
    if (pix_rd_en) begin
      if (rd_count < 64) rd_log[rd_count] = pix_addr;
      if (int'(pix_addr) > NUM_LEDS - 1) addr_err++;
      rd_count++;
    end
    if (reset_finish) rf_count++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // A pixel boundary must always find the next pixel already prefetched.
  assert property (@(posedge clk) disable iff (!rstn)
                   (dut.serve && dut.last_bit && dut.more_pix) |-> dut.next_valid)
    else check("prefetch_ready", 64'(dut.next_valid), 64'd1);

  task automatic pulse_start();
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  // Sample the current bit, then consume it with a one-cycle request; optional frame_start at bit fs_at.
  task automatic stream(input int nbits, input int fs_at, output logic [47:0] got);
    got = '0;
    for (int i = 0; i < nbits; i++) begin
      repeat (GAP - 1) @(negedge clk);
      got = {got[46:0], bit_to_transmit};
      new_bit_rqst = 1'b1;
      if (i == fs_at) frame_start = 1'b1;
      @(negedge clk);
      new_bit_rqst = 1'b0;
      frame_start  = 1'b0;
    end
  endtask

  task automatic wait_done(output int k);
    k = 0;
    while (!reset_finish && k < 4 * RC) begin
      @(negedge clk);
      k++;
    end
    if (!reset_finish) check("done_timeout", 64'(reset_finish), 64'd1);
  endtask

  initial begin
    logic [47:0] got;
    int k;
    int base;
    int rf_base;

    mem[0] = 24'hFF0000;
    mem[1] = 24'h00000F;
    mem[2] = 24'h123456;
    mem[3] = 24'h654321;
`ifdef LED_SEQ_AUTO_REFRESH_EN
    mem[0] = 24'hA5A5A5;
`endif

    repeat (3) @(negedge clk);
    check("rst_busy",  64'(busy), 64'd0);
    check("rst_rd_en", 64'(pix_rd_en), 64'd0);
    check("rst_addr",  64'(pix_addr), 64'd0);
    check("rst_bit",   64'(bit_to_transmit), 64'd0);
    check("rst_abs",   64'(all_bits_shifted), 64'd0);
    check("rst_flags", 64'({frame_done, reset_finish}), 64'd0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

`ifdef LED_SEQ_AUTO_REFRESH_EN
    pulse_start();
    stream(BPP, -1, got);
    check("auto_f1_bits", 64'(got[23:0]), 64'hA5A5A5);
    check("auto_f1_abs", 64'(all_bits_shifted), 64'd1);
    wait_done(k);
    check("auto_f1_latch", 64'(k), 64'(RC));
    check("auto_f1_done", 64'(frame_done), 64'd1);
    check("auto_f1_busy", 64'(busy), 64'd1);
    stream(BPP, -1, got);
    check("auto_f2_bits", 64'(got[23:0]), 64'hA5A5A5);
    auto_refresh_stop = 1'b1;
    wait_done(k);
    check("auto_f2_latch", 64'(k), 64'(RC));
    check("auto_f2_done", 64'(frame_done), 64'd1);
    check("auto_stop_busy", 64'(busy), 64'd0);
    repeat (20) @(negedge clk);
    check("auto_stop_idle", 64'(busy), 64'd0);
    check("auto_reads", 64'(rd_count), 64'd2);
    check("auto_rd_addr", 64'({rd_log[0], rd_log[1]}), 64'd0);
    check("auto_addr_range", 64'(addr_err), 64'd0);
    check("auto_rf_pulses", 64'(rf_count), 64'd2);
`else
    // Requests in IDLE do nothing.
    new_bit_rqst = 1'b1;
    @(negedge clk);
    new_bit_rqst = 1'b0;
    @(negedge clk);
    check("idle_rqst_bit", 64'(bit_to_transmit), 64'd0);
    check("idle_rqst_busy", 64'(busy), 64'd0);
    check("idle_rqst_reads", 64'(rd_count), 64'd0);

    // Full frame with a frame_start pulsed mid-frame.
    base = rd_count;
    pulse_start();
    check("busy_after_start", 64'(busy), 64'd1);
    stream(48, 20, got);
    check("frame1_bits", 64'(got), 64'hFF000000000F);
    check("frame1_abs", 64'(all_bits_shifted), 64'd1);
    check("frame1_abs_bit", 64'(bit_to_transmit), 64'd0);
    for (int j = 0; j < 5; j++) begin
      if (j == 2) new_bit_rqst = 1'b1;
      @(negedge clk);
      new_bit_rqst = 1'b0;
    end
    check("latch_rqst_abs", 64'(all_bits_shifted), 64'd1);
    check("latch_rqst_bit", 64'(bit_to_transmit), 64'd0);
    wait_done(k);
    check("latch_len", 64'(k + 5), 64'(RC));
    check("done_pulse", 64'(frame_done), 64'd1);
    check("done_busy", 64'(busy), 64'd0);
    check("done_abs", 64'(all_bits_shifted), 64'd0);
    pulse_start();
    check("rf_one_cycle", 64'({reset_finish, frame_done}), 64'd0);
    repeat (10) @(negedge clk);
    check("start_at_done_ignored", 64'(busy), 64'd0);
    check("frame1_reads", 64'(rd_count - base), 64'd2);
    check("frame1_rd_addrs", 64'({rd_log[base], rd_log[base + 1]}), 64'b01);
    check("frame1_rf_pulses", 64'(rf_count), 64'd1);

    // Asynchronous reset at bit 30, then a clean full frame.
    pulse_start();
    stream(30, -1, got);
    check("pre_rst_addr", 64'(pix_addr), 64'd1);
    rf_base = rf_count;
    rstn = 1'b0;
    #1;
    check("async_busy", 64'(busy), 64'd0);
    check("async_addr", 64'(pix_addr), 64'd0);
    check("async_outs", 64'({pix_rd_en, bit_to_transmit, all_bits_shifted, reset_finish, frame_done}), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (RC + 10) @(negedge clk);
    check("no_rf_after_rst", 64'(rf_count - rf_base), 64'd0);
    check("idle_after_rst", 64'(busy), 64'd0);
    base = rd_count;
    pulse_start();
    stream(48, -1, got);
    check("frame2_bits", 64'(got), 64'hFF000000000F);
    wait_done(k);
    check("frame2_latch", 64'(k), 64'(RC));
    repeat (5) @(negedge clk);
    check("frame2_reads", 64'(rd_count - base), 64'd2);
    check("frame2_first_addr", 64'(rd_log[base]), 64'd0);
    check("addr_range", 64'(addr_err), 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
